// File: rtl/fric_client.sv
// fric_client: register-access endpoint on the FRIC byte link.
// Decodes write/read request frames into register strobes and returns ack/reply frames.
module fric_client #(
  parameter logic [3:0] PORT_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fric_in,
  output logic [7:0]  fric_out,
  output logic [7:0]  addr,
  output logic        wr_strobe,
  output logic [15:0] wr_data,
  output logic        rd_strobe,
  input  logic [15:0] rd_data,
  output logic        err_overflow
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;

  localparam logic [3:0] TYPE_WR   = 4'h1;
  localparam logic [3:0] TYPE_RD   = 4'h2;
  localparam logic [3:0] TYPE_ACK  = 4'h3;
  localparam logic [3:0] TYPE_RPLY = 4'h4;

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_DLO, RX_DHI} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_T0, TX_T1, TX_T2, TX_T3} tx_state_e;

  rx_state_e           rx_state_q;
  logic                rx_wr_q;
  logic                rx_hit_q;
  logic [ADDR_W-1:0]   rx_addr_q;
  logic [7:0]          rx_dlo_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                wr_strobe_q;
  logic                rd_strobe_q;
  logic                rd_cap_q;

  tx_state_e           tx_state_q;
  logic [7:0]          fric_out_q;
  logic                act_rd_q;
  logic [ADDR_W-1:0]   act_addr_q;
  logic [DATA_W-1:0]   act_data_q;
  logic                pend_vld_q;
  logic                pend_rd_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic [DATA_W-1:0]   pend_data_q;
  logic                err_q;

  logic                tx_free_d;
  logic                new_vld_d;
  logic                new_rd_d;
  logic [DATA_W-1:0]   new_data_d;

  function automatic logic [7:0] rsp_hdr(input logic is_rd);
    return {(is_rd ? TYPE_RPLY : TYPE_ACK), PORT_ID};
  endfunction

  // Receive FSM: frame parsing and register strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q  <= RX_IDLE;
      rx_wr_q     <= 1'b0;
      rx_hit_q    <= 1'b0;
      rx_addr_q   <= '0;
      rx_dlo_q    <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      rd_cap_q    <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      rd_cap_q    <= rd_strobe_q;
      case (rx_state_q)
        RX_IDLE: begin
          if (fric_in[7:4] == TYPE_WR || fric_in[7:4] == TYPE_RD) begin
            rx_state_q <= RX_ADDR;
            rx_wr_q    <= (fric_in[7:4] == TYPE_WR);
            rx_hit_q   <= (fric_in[3:0] == PORT_ID);
          end
        end
        RX_ADDR: begin
          if (rx_wr_q) begin
            rx_addr_q  <= fric_in;
            rx_state_q <= RX_DLO;
          end else begin
            rx_state_q <= RX_IDLE;
            if (rx_hit_q) begin
              rd_strobe_q <= 1'b1;
              addr_q      <= fric_in;
            end
          end
        end
        RX_DLO: begin
          rx_dlo_q   <= fric_in;
          rx_state_q <= RX_DHI;
        end
        RX_DHI: begin
          rx_state_q <= RX_IDLE;
          if (rx_hit_q) begin
            wr_strobe_q <= 1'b1;
            addr_q      <= rx_addr_q;
            wr_data_q   <= {fric_in, rx_dlo_q};
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // A write ack is ready in the strobe cycle; a read reply once rd_data is valid
  always_comb begin
    tx_free_d  = (tx_state_q == TX_IDLE) || (tx_state_q == TX_T3) ||
                 (tx_state_q == TX_T1 && !act_rd_q);
    new_vld_d  = wr_strobe_q || rd_cap_q;
    new_rd_d   = rd_cap_q;
    new_data_d = rd_cap_q ? rd_data : DATA_W'(0);
  end

  // Transmit FSM with one active and one pending response slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q  <= TX_IDLE;
      fric_out_q  <= 8'h00;
      act_rd_q    <= 1'b0;
      act_addr_q  <= '0;
      act_data_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_rd_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      err_q       <= 1'b0;
    end else if (tx_free_d) begin
      if (pend_vld_q) begin
        tx_state_q <= TX_T0;
        fric_out_q <= rsp_hdr(pend_rd_q);
        act_rd_q   <= pend_rd_q;
        act_addr_q <= pend_addr_q;
        act_data_q <= pend_data_q;
        pend_vld_q <= new_vld_d;
        if (new_vld_d) begin
          pend_rd_q   <= new_rd_d;
          pend_addr_q <= addr_q;
          pend_data_q <= new_data_d;
        end
      end else if (new_vld_d) begin
        tx_state_q <= TX_T0;
        fric_out_q <= rsp_hdr(new_rd_d);
        act_rd_q   <= new_rd_d;
        act_addr_q <= addr_q;
        act_data_q <= new_data_d;
      end else begin
        tx_state_q <= TX_IDLE;
        fric_out_q <= 8'h00;
      end
    end else begin
      case (tx_state_q)
        TX_T0: begin
          tx_state_q <= TX_T1;
          fric_out_q <= act_addr_q;
        end
        TX_T1: begin
          tx_state_q <= TX_T2;
          fric_out_q <= act_data_q[7:0];
        end
        TX_T2: begin
          tx_state_q <= TX_T3;
          fric_out_q <= act_data_q[15:8];
        end
        default: begin
          tx_state_q <= TX_IDLE;
          fric_out_q <= 8'h00;
        end
      endcase
      if (new_vld_d) begin
        if (pend_vld_q) begin
          err_q <= 1'b1;
        end else begin
          pend_vld_q  <= 1'b1;
          pend_rd_q   <= new_rd_d;
          pend_addr_q <= addr_q;
          pend_data_q <= new_data_d;
        end
      end
    end
  end

  assign fric_out     = fric_out_q;
  assign addr         = addr_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_data      = wr_data_q;
  assign rd_strobe    = rd_strobe_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_fric_client.sv
// tb_fric_client: directed bench for fric_client with cycle-stamped scoreboards
// for the response stream, register strobes and the overflow flag.
module tb_fric_client;

  localparam logic [3:0] PID = 4'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  fric_in = 8'h00;
  logic [7:0]  fric_out;
  logic [7:0]  addr;
  logic        wr_strobe;
  logic [15:0] wr_data;
  logic        rd_strobe;
  logic [15:0] rd_data = 16'hDEAD;
  logic        err_overflow;

  fric_client #(.PORT_ID(PID)) dut (
    .clk          (clk),
    .rst          (rst),
    .fric_in      (fric_in),
    .fric_out     (fric_out),
    .addr         (addr),
    .wr_strobe    (wr_strobe),
    .wr_data      (wr_data),
    .rd_strobe    (rd_strobe),
    .rd_data      (rd_data),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] b; } out_t;
  typedef struct { int cyc; logic wr; logic [7:0] a; logic [15:0] d; } stb_t;
  typedef struct { int cyc; logic val; } ovf_t;

  out_t        out_q[$];
  stb_t        stb_q[$];
  ovf_t        ovf_q[$];
  logic [15:0] rdd_q[$];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  bit chk = 1'b0;
  bit done = 1'b0;
  int last_start = -100;
  int last_end = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file side: present the queued read value in the cycle after rd_strobe
  logic take;
  always begin
    @(negedge clk);
    take = rd_strobe;
    @(posedge clk);
    #1;
    if (take === 1'b1 && rdd_q.size() > 0) rd_data = rdd_q.pop_front();
    else rd_data = 16'hDEAD;
  end

  task automatic send(input logic [7:0] b);
    fric_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h00);
  endtask

  // Response ready at arr: starts after the previous one, dropped if one is still waiting
  task automatic sched(input int arr, input int len, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bs [4];
    out_t o;
    ovf_t v;
    int s;
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    if (last_start > arr) begin
      v.cyc = arr; v.val = 1'b1;
      ovf_q.push_back(v);
    end else begin
      s = (arr > last_end + 1) ? arr : last_end + 1;
      for (int i = 0; i < len; i++) begin
        o.cyc = s + i; o.b = bs[i];
        out_q.push_back(o);
      end
      last_start = s;
      last_end = s + len - 1;
    end
  endtask

  task automatic wr_frame(input logic [3:0] port, input logic [7:0] a, input logic [15:0] d);
    int k;
    stb_t s;
    send({4'h1, port});
    send(a);
    send(d[7:0]);
    k = cyc;
    send(d[15:8]);
    if (port == PID) begin
      s.cyc = k + 1; s.wr = 1'b1; s.a = a; s.d = d;
      stb_q.push_back(s);
      sched(k + 2, 2, {4'h3, PID}, a, 8'h00, 8'h00);
    end
  endtask

  task automatic rd_frame(input logic [3:0] port, input logic [7:0] a, input logic [15:0] d);
    int k;
    stb_t s;
    send({4'h2, port});
    k = cyc;
    send(a);
    if (port == PID) begin
      rdd_q.push_back(d);
      s.cyc = k + 1; s.wr = 1'b0; s.a = a; s.d = 16'h0000;
      stb_q.push_back(s);
      sched(k + 3, 4, {4'h4, PID}, a, d[7:0], d[15:8]);
    end
  endtask

  // Per-cycle checker
  out_t        m_o;
  stb_t        m_s;
  ovf_t        m_v;
  logic [7:0]  eb;
  logic        ew, er;
  logic [7:0]  ea;
  logic [15:0] ed;
  logic        e_ovf = 1'b0;

  always @(negedge clk) begin
    if (chk) begin
      eb = 8'h00;
      if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
        m_o = out_q.pop_front();
        eb = m_o.b;
      end
      ew = 1'b0; er = 1'b0; ea = 8'h00; ed = 16'h0000;
      if (stb_q.size() > 0 && stb_q[0].cyc == cyc) begin
        m_s = stb_q.pop_front();
        ew = m_s.wr; er = !m_s.wr; ea = m_s.a; ed = m_s.d;
      end
      while (ovf_q.size() > 0 && ovf_q[0].cyc <= cyc) begin
        m_v = ovf_q.pop_front();
        e_ovf = m_v.val;
      end

      n_assert++;
      assert (fric_out === eb) else begin
        n_fail++;
        $error("FAIL fric_out cyc=%0d observed=%h expected=%h", cyc, fric_out, eb);
      end
      n_assert++;
      assert ({wr_strobe, rd_strobe} === {ew, er}) else begin
        n_fail++;
        $error("FAIL strobes cyc=%0d observed wr/rd=%b%b expected=%b%b", cyc, wr_strobe, rd_strobe, ew, er);
      end
      if (ew || er) begin
        n_assert++;
        assert (addr === ea) else begin
          n_fail++;
          $error("FAIL addr cyc=%0d observed=%h expected=%h", cyc, addr, ea);
        end
      end
      if (ew) begin
        n_assert++;
        assert (wr_data === ed) else begin
          n_fail++;
          $error("FAIL wr_data cyc=%0d observed=%h expected=%h", cyc, wr_data, ed);
        end
      end
      n_assert++;
      assert (err_overflow === e_ovf) else begin
        n_fail++;
        $error("FAIL err_overflow cyc=%0d observed=%b expected=%b", cyc, err_overflow, e_ovf);
      end
    end

    if (done) begin
      n_assert++;
      assert (out_q.size() == 0) else begin
        n_fail++;
        $error("FAIL resp_drain observed=%0d left expected=0", out_q.size());
      end
      n_assert++;
      assert (stb_q.size() == 0) else begin
        n_fail++;
        $error("FAIL strobe_drain observed=%0d left expected=0", stb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
    end
  end

  initial begin
    int c;
    ovf_t v;
    rst = 1'b0;
    fric_in = 8'h00;
    @(posedge clk);
    #1;
    chk = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    idle(2);

    wr_frame(PID, 8'h12, 16'hABCD);
    idle(6);

    rd_frame(PID, 8'h34, 16'h5A69);
    idle(8);

    wr_frame(4'h5, 8'h01, 16'hFFFF);
    rd_frame(PID, 8'h56, 16'h1234);
    idle(8);

    rd_frame(PID, 8'h01, 16'h00FF);
    rd_frame(PID, 8'h02, 16'h0000);
    rd_frame(PID, 8'h03, 16'hC3A5);
    idle(16);

    rd_frame(PID, 8'h10, 16'h1111);
    rd_frame(PID, 8'h11, 16'h2222);
    rd_frame(PID, 8'h12, 16'h3333);
    rd_frame(PID, 8'h13, 16'h4444);
    rd_frame(PID, 8'h14, 16'h5555);
    idle(20);

    send(8'h7F);
    wr_frame(PID, 8'h9A, 16'h0102);
    idle(8);

    send({4'h1, PID});
    rst = 1'b0;
    c = cyc;
    v.cyc = c + 1; v.val = 1'b0;
    ovf_q.push_back(v);
    send(8'h77);
    send(8'h00);
    send(8'h00);
    rst = 1'b1;
    idle(2);

    rd_frame(PID, 8'h44, 16'hBEEF);
    wr_frame(PID, 8'h45, 16'h00A0);
    idle(10);
    done = 1'b1;
  end

endmodule
